// File: rtl/serial_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_link_pkg
// Description : Shared constants and state encoding for the one-wire byte
//               link (serial transmitter and serial_receiver).
// Revision    : 1.0 - initial release
// ============================================================================
package serial_link_pkg;

    // Number of data bits carried by one frame
    localparam int C_FRAME_WIDTH = 8;

    // Line levels: a single high cycle marks a start, the line rests low
    localparam logic C_START_LEVEL = 1'b1;
    localparam logic C_IDLE_LEVEL  = 1'b0;

    // Link FSM state encoding
    localparam int C_STATE_W = 2;
    typedef enum logic [C_STATE_W-1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        GUARD = 2'd2
    } link_state_e;

endpackage : serial_link_pkg
`default_nettype wire

// File: rtl/serial_receiver.sv
`default_nettype none
// ============================================================================
// Module      : serial_receiver
// Description : One-wire serial-to-parallel byte receiver. Detects a single
//               high start cycle, shifts in 8 data bits LSB first and
//               presents the byte with a Valid/Ack handshake and a sticky
//               Overrun flag.
//               Optional macro RX_GUARD_CHECK_EN adds a mandatory low guard
//               cycle after bit 7; a high guard pulses FrameErr and drops
//               the byte.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_receiver
    import serial_link_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       SDin,
    input  logic       Ack,
    output logic [7:0] PDout,
    output logic       Valid,
    output logic       Busy,
    output logic       Overrun,
    output logic       FrameErr
);

`ifdef RX_GUARD_CHECK_EN
    // The whole byte must be held through the guard cycle
    localparam int C_SHIFT_W = C_FRAME_WIDTH;
`else
    // Bit 7 is taken straight from the line on the completing edge
    localparam int C_SHIFT_W = C_FRAME_WIDTH - 1;
`endif

    link_state_e          r_state_q,   w_state_d;
    logic [2:0]           r_cnt_q,     w_cnt_d;
    logic [C_SHIFT_W-1:0] r_shift_q,   w_shift_d;
    logic [7:0]           r_pdout_q,   w_pdout_d;
    logic                 r_valid_q,   w_valid_d;
    logic                 r_overrun_q, w_overrun_d;
    logic [7:0]           w_full;
    logic [7:0]           w_byte;
    logic                 w_complete;
`ifdef RX_GUARD_CHECK_EN
    logic                 r_frame_err_q, w_frame_err_d;
`endif

    // Byte as it would stand if the current line sample were the final bit
    assign w_full = {SDin, r_shift_q[C_SHIFT_W-1 -: 7]};

    // Next-state, shift/count and handshake logic
    always_comb begin
        w_state_d   = r_state_q;
        w_cnt_d     = r_cnt_q;
        w_shift_d   = r_shift_q;
        w_pdout_d   = r_pdout_q;
        w_valid_d   = r_valid_q;
        w_overrun_d = r_overrun_q;
        w_byte      = w_full;
        w_complete  = 1'b0;
`ifdef RX_GUARD_CHECK_EN
        w_frame_err_d = 1'b0;
`endif
        case (r_state_q)
            IDLE: begin
                if (SDin == C_START_LEVEL) begin
                    w_state_d = DATA;
                    w_cnt_d   = 3'd0;
                end
            end
            DATA: begin
                w_shift_d = w_full[7 -: C_SHIFT_W];
                w_cnt_d   = r_cnt_q + 3'd1;
                if (r_cnt_q == 3'd7) begin
`ifdef RX_GUARD_CHECK_EN
                    w_state_d = GUARD;
`else
                    w_state_d  = IDLE;
                    w_complete = 1'b1;
`endif
                end
            end
`ifdef RX_GUARD_CHECK_EN
            GUARD: begin
                // A high guard is a framing error, never a new start
                w_state_d = IDLE;
                w_byte    = r_shift_q;
                if (SDin == C_IDLE_LEVEL) begin
                    w_complete = 1'b1;
                end else begin
                    w_frame_err_d = 1'b1;
                end
            end
`endif
            default: w_state_d = IDLE;
        endcase

        // Completion wins over a coincident Ack; Ack still clears Overrun
        if (w_complete) begin
            w_pdout_d = w_byte;
            w_valid_d = 1'b1;
            if (r_valid_q && !Ack) begin
                w_overrun_d = 1'b1;
            end else if (Ack) begin
                w_overrun_d = 1'b0;
            end
        end else if (Ack) begin
            w_valid_d   = 1'b0;
            w_overrun_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state_q   <= IDLE;
            r_cnt_q     <= 3'd0;
            r_shift_q   <= '0;
            r_pdout_q   <= 8'h00;
            r_valid_q   <= 1'b0;
            r_overrun_q <= 1'b0;
`ifdef RX_GUARD_CHECK_EN
            r_frame_err_q <= 1'b0;
`endif
        end else begin
            r_state_q   <= w_state_d;
            r_cnt_q     <= w_cnt_d;
            r_shift_q   <= w_shift_d;
            r_pdout_q   <= w_pdout_d;
            r_valid_q   <= w_valid_d;
            r_overrun_q <= w_overrun_d;
`ifdef RX_GUARD_CHECK_EN
            r_frame_err_q <= w_frame_err_d;
`endif
        end
    end

    assign PDout   = r_pdout_q;
    assign Valid   = r_valid_q;
    assign Overrun = r_overrun_q;
    assign Busy    = (r_state_q != IDLE);
`ifdef RX_GUARD_CHECK_EN
    assign FrameErr = r_frame_err_q;
`else
    assign FrameErr = 1'b0;
`endif

endmodule : serial_receiver
`default_nettype wire

// File: tb/tb_serial_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_receiver
// Description : Self-checking bench for serial_receiver. A frame-level model
//               tracks the expected outputs; directed frames pin known bytes
//               and random traffic exercises the handshake and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_receiver;

`ifdef RX_GUARD_CHECK_EN
    localparam int GX = 1;
`else
    localparam int GX = 0;
`endif

    logic       Clk   = 1'b0;
    logic       Rst_n = 1'b0;
    logic       SDin  = 1'b0;
    logic       Ack   = 1'b0;
    logic [7:0] PDout;
    logic       Valid, Busy, Overrun, FrameErr;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 Clk = ~Clk;

    serial_receiver dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .SDin     (SDin),
        .Ack      (Ack),
        .PDout    (PDout),
        .Valid    (Valid),
        .Busy     (Busy),
        .Overrun  (Overrun),
        .FrameErr (FrameErr)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference model
    logic [7:0] m_pd = 8'h00;
    logic [7:0] m_acc = 8'h00;
    bit m_valid = 0, m_overrun = 0, m_ferr = 0, m_rx = 0, m_guard = 0;
    int m_n = 0;

    always @(posedge Clk) begin
        bit done, ferr;
        logic [7:0] nb;
        done = 0; ferr = 0; nb = 8'h00;
        if (!Rst_n) begin
            m_pd = 8'h00; m_valid = 0; m_overrun = 0; m_ferr = 0;
            m_rx = 0; m_guard = 0; m_n = 0; m_acc = 8'h00;
        end else begin
            if (m_guard) begin
                m_guard = 0;
                if (!SDin) begin done = 1; nb = m_acc; end
                else ferr = 1;
            end else if (m_rx) begin
                m_acc = m_acc | (8'(SDin) << m_n);
                m_n++;
                if (m_n == 8) begin
                    m_rx = 0;
                    if (GX != 0) m_guard = 1;
                    else begin done = 1; nb = m_acc; end
                end
            end else if (SDin) begin
                m_rx = 1; m_n = 0; m_acc = 8'h00;
            end
            if (done) begin
                if (m_valid && !Ack) m_overrun = 1;
                else if (Ack) m_overrun = 0;
                m_valid = 1;
                m_pd = nb;
            end else if (Ack) begin
                m_valid = 0;
                m_overrun = 0;
            end
            m_ferr = ferr;
        end
    end

    // Compare every output against the model away from the active edge
    always @(negedge Clk) begin
        if (chk_en) begin
            chk("PDout",    PDout,          m_pd);
            chk("Valid",    8'(Valid),      8'(m_valid));
            chk("Busy",     8'(Busy),       8'(m_rx || m_guard));
            chk("Overrun",  8'(Overrun),    8'(m_overrun));
            chk("FrameErr", 8'(FrameErr),   8'(m_ferr));
        end
    end

    task automatic cyc(input logic sd, input logic ak, input logic rn);
        @(negedge Clk);
        SDin  = sd;
        Ack   = ak;
        Rst_n = rn;
    endtask

    // Start cycle, 8 data bits LSB first, then the guard cycle if present.
    // ack_done is applied on the edge that completes the frame.
    task automatic send_byte(input logic [7:0] b, input logic ack_start,
                             input logic ack_done, input logic guard_bit);
        cyc(1'b1, ack_start, 1'b1);
        for (int i = 0; i < 8; i++)
            cyc(b[i], (i == 7 && GX == 0) ? ack_done : 1'b0, 1'b1);
        if (GX != 0) cyc(guard_bit, ack_done, 1'b1);
    endtask

    initial begin
        logic [7:0] b5a;
        b5a = 8'h5A;
        cyc(1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("rst_pd",   PDout, 8'h00);
        chk("rst_val",  8'(Valid), 8'h00);
        chk("rst_busy", 8'(Busy), 8'h00);
        chk("rst_ovr",  8'(Overrun), 8'h00);
        chk("rst_ferr", 8'(FrameErr), 8'h00);

        // First frame 8'hA5
        send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("a5_pd",   PDout, 8'hA5);
        chk("a5_val",  8'(Valid), 8'h01);
        chk("a5_busy", 8'(Busy), 8'h00);
        cyc(1'b0, 1'b1, 1'b1);

        // 8'hFF, then Ack together with the next start, then 8'h00
        send_byte(8'hFF, 1'b0, 1'b0, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("b2b_pd",  PDout, 8'h00);
        chk("b2b_val", 8'(Valid), 8'h01);
        chk("b2b_ovr", 8'(Overrun), 8'h00);
        cyc(1'b0, 1'b1, 1'b1);

        // Two frames without Ack -> overrun
        send_byte(8'h3C, 1'b0, 1'b0, 1'b0);
        send_byte(8'hC3, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("ovr_pd",  PDout, 8'hC3);
        chk("ovr_set", 8'(Overrun), 8'h01);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("ack_val", 8'(Valid), 8'h00);
        chk("ack_ovr", 8'(Overrun), 8'h00);

        // Reset in the middle of bit 4 of 8'h5A
        cyc(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(b5a[i], 1'b0, 1'b1);
        chk("mid_busy", 8'(Busy), 8'h01);
        cyc(b5a[4], 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("mrst_pd",   PDout, 8'h00);
        chk("mrst_val",  8'(Valid), 8'h00);
        chk("mrst_busy", 8'(Busy), 8'h00);
        send_byte(8'h81, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("post_pd",  PDout, 8'h81);
        chk("post_val", 8'(Valid), 8'h01);

        // Ack on the completing edge while Valid is still high
        send_byte(8'h6B, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("coinc_pd",  PDout, 8'h6B);
        chk("coinc_val", 8'(Valid), 8'h01);
        chk("coinc_ovr", 8'(Overrun), 8'h00);

`ifdef RX_GUARD_CHECK_EN
        cyc(1'b0, 1'b1, 1'b1);
        send_byte(8'h12, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("gerr_ferr", 8'(FrameErr), 8'h01);
        chk("gerr_val",  8'(Valid), 8'h00);
        chk("gerr_pd",   PDout, 8'h6B);
        cyc(1'b0, 1'b0, 1'b1);
        chk("gerr_pulse", 8'(FrameErr), 8'h00);
        chk("gerr_busy",  8'(Busy), 8'h00);
        send_byte(8'h12, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("gok_pd",  PDout, 8'h12);
        chk("gok_val", 8'(Valid), 8'h01);
`endif

        // Random line traffic, acks and occasional resets
        for (int k = 0; k < 4000; k++)
            cyc(($urandom % 3) == 0, ($urandom % 6) == 0, ($urandom % 300) != 0);

        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_receiver
`default_nettype wire
